// File: rtl/shift_pkg.sv
// Shared types and the pure next-state function for univ_shift_reg.
// Values travel right-aligned in a MAX_W-bit word so one function serves every width.
package shift_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    ROL = 2'd2,
    ROR = 2'd3
  } shift_mode_e;

  // dw/sw are elaboration constants at every RTL call site, so the shifts reduce to wiring.
  function automatic word_t shift_next(input word_t       q,
                                       input shift_mode_e mode,
                                       input word_t       lane_in,
                                       input int unsigned dw,
                                       input int unsigned sw);
    word_t mask_dw, mask_sw, cur, lane, hi, lo, r;
    mask_dw = (dw >= MAX_W) ? '1 : ((word_t'(1) << dw) - word_t'(1));
    mask_sw = (word_t'(1) << sw) - word_t'(1);
    cur     = q & mask_dw;
    lane    = lane_in & mask_sw;
    hi      = (cur >> (dw - sw)) & mask_sw;
    lo      = cur & mask_sw;
    case (mode)
      SHL:     r = (cur << sw) | lane;
      SHR:     r = (cur >> sw) | (lane << (dw - sw));
      ROL:     r = (cur << sw) | hi;
      default: r = (cur >> sw) | (lo << (dw - sw));
    endcase
    return r & mask_dw;
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal load/shift/rotate register with SW-bit lanes and a shift-frame counter.
// Define UNIV_SHIFT_ARITH_EN to add the `arith` input (sign-extending SHR).
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 1,
  parameter type         dw_t = logic [DW-1:0],
  localparam int unsigned NSH = DW / SW,
  localparam int unsigned CW  = $clog2(NSH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  dw_t           d,
  input  logic          shift,
  input  shift_mode_e   mode,
  input  logic [SW-1:0] serial_in,
`ifdef UNIV_SHIFT_ARITH_EN
  input  logic          arith,
`endif
  output dw_t           q,
  output logic [SW-1:0] serial_out,
  output logic [CW-1:0] shift_cnt,
  output logic          frame_done
);

  if (DW < 2 || SW < 1 || SW >= DW || (DW % SW) != 0 || DW > MAX_W) begin : g_param_check
    $error("univ_shift_reg: illegal parameters DW=%0d SW=%0d", DW, SW);
  end

  dw_t           r_q;
  logic [CW-1:0] r_cnt;
  logic          r_frame_done;
  logic [SW-1:0] w_lane;
  dw_t           w_next;
  logic          w_wrap;

  // Lane entering on SHL/SHR; rotates ignore it inside shift_next.
  always_comb begin
    w_lane = serial_in;
`ifdef UNIV_SHIFT_ARITH_EN
    if (arith && mode == SHR) w_lane = {SW{r_q[DW-1]}};
`endif
  end

  assign w_next = DW'(shift_next(word_t'(r_q), mode, word_t'(w_lane), DW, SW));
  assign w_wrap = (r_cnt == CW'(NSH - 1));

  always_comb begin
    serial_out = r_q[SW-1:0];
    if (mode == SHL || mode == ROL) serial_out = r_q[DW-1 -: SW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q          <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else if (load) begin
      r_q          <= d;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else if (shift) begin
      r_q          <= w_next;
      r_cnt        <= w_wrap ? '0 : r_cnt + CW'(1);
      r_frame_done <= w_wrap;
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  assign q          = r_q;
  assign shift_cnt  = r_cnt;
  assign frame_done = r_frame_done;

endmodule
